// File: rtl/led_page_scanner.sv
`default_nettype none
// ============================================================================
// Module  : led_page_scanner
// Brief   : Pages captured data words and ZF/OF flags onto an LED bank,
//           selected manually or by a prescaled auto scan.
// Revision: 1.0
// ============================================================================
module led_page_scanner #(
  parameter int DATA_W   = 32,
  parameter int NCH      = 2,
  parameter int LED_W    = 8,
  parameter int SEL_W    = 4,
  parameter int SCAN_DIV = 25000000
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NCH*DATA_W-1:0] Data,
  input  logic                  ZF,
  input  logic                  OF,
  input  logic [SEL_W-1:0]      Sel,
  input  logic                  Auto,
  input  logic                  Freeze,
  input  logic                  ClrSticky,
  output logic [LED_W-1:0]      LED,
  output logic [SEL_W-1:0]      PageIdx
);

  localparam int NSL   = DATA_W / LED_W;
  localparam int NDP   = NCH * NSL;
  localparam int NPAGE = NDP + 1;
  localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0]    c_presc_last = PW'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] c_page_last  = SEL_W'(NPAGE - 1);

  logic [NCH*DATA_W-1:0] r_cap_data;
  logic                  r_cap_zf;
  logic                  r_cap_of;
  logic                  r_sticky_zf;
  logic                  r_sticky_of;
  logic [PW-1:0]         r_presc;
  logic [SEL_W-1:0]      r_scan;
  logic                  r_auto_d;

  logic                  w_auto_entry;
  logic                  w_presc_tc;
  logic [PW-1:0]         w_presc_nxt;
  logic [SEL_W-1:0]      w_scan_nxt;
  logic [SEL_W-1:0]      w_page;
  logic [LED_W-1:0]      w_flags;
  logic [LED_W-1:0]      w_led_nxt;

  assign w_auto_entry = Auto & ~r_auto_d;
  assign w_presc_tc   = (r_presc == c_presc_last);

  always_comb begin
    w_presc_nxt = r_presc;
    w_scan_nxt  = r_scan;
    if (w_auto_entry) begin
      w_presc_nxt = '0;
      w_scan_nxt  = '0;
    end else if (Auto) begin
      if (w_presc_tc) begin
        w_presc_nxt = '0;
        w_scan_nxt  = (r_scan == c_page_last) ? '0 : r_scan + SEL_W'(1);
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end
  end

  // Auto mode shows the page the scan register is about to hold, so the
  // entry cycle already displays page 0 and every page dwells SCAN_DIV clocks.
  assign w_page = Auto ? w_scan_nxt : Sel;

  always_comb begin
    w_flags            = '0;
    w_flags[LED_W-1]   = r_cap_of;
    w_flags[LED_W-2]   = r_cap_zf;
    w_flags[LED_W-3]   = r_sticky_of;
    w_flags[LED_W-4]   = r_sticky_zf;
  end

  // Data pages are consecutive LED_W slices of the flat capture vector.
  always_comb begin
    w_led_nxt = '0;
    for (int p = 0; p < NDP; p++) begin
      if (w_page == SEL_W'(p)) begin
        w_led_nxt = r_cap_data[p*LED_W +: LED_W];
      end
    end
    if (w_page == c_page_last) begin
      w_led_nxt = w_flags;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_cap_data  <= '0;
      r_cap_zf    <= 1'b0;
      r_cap_of    <= 1'b0;
      r_sticky_zf <= 1'b0;
      r_sticky_of <= 1'b0;
      r_presc     <= '0;
      r_scan      <= '0;
      r_auto_d    <= 1'b0;
      LED         <= '0;
      PageIdx     <= '0;
    end else begin
      if (!Freeze) begin
        r_cap_data <= Data;
        r_cap_zf   <= ZF;
        r_cap_of   <= OF;
      end
      // Sticky bits follow the live flags; a set beats a simultaneous clear.
      r_sticky_zf <= (r_sticky_zf & ~ClrSticky) | ZF;
      r_sticky_of <= (r_sticky_of & ~ClrSticky) | OF;
      r_presc     <= w_presc_nxt;
      r_scan      <= w_scan_nxt;
      r_auto_d    <= Auto;
      LED         <= w_led_nxt;
      PageIdx     <= w_page;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_page_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_page_scanner
// Brief   : Self-checking bench for led_page_scanner (vectors, sequences,
//           randomized run against a page-level reference model).
// Revision: 1.0
// ============================================================================
module tb_led_page_scanner;

  localparam int DATA_W   = 32;
  localparam int NCH      = 2;
  localparam int LED_W    = 8;
  localparam int SEL_W    = 4;
  localparam int SCAN_DIV = 4;
  localparam int NSL      = DATA_W / LED_W;
  localparam int NPAGE    = NCH * NSL + 1;

  logic                  Clk = 1'b0;
  logic                  Rst = 1'b1;
  logic [NCH*DATA_W-1:0] Data = '0;
  logic                  ZF = 1'b0;
  logic                  OF = 1'b0;
  logic [SEL_W-1:0]      Sel = '0;
  logic                  Auto = 1'b0;
  logic                  Freeze = 1'b0;
  logic                  ClrSticky = 1'b0;
  logic [LED_W-1:0]      LED;
  logic [SEL_W-1:0]      PageIdx;

  int checks   = 0;
  int failures = 0;

  led_page_scanner #(
    .DATA_W(DATA_W), .NCH(NCH), .LED_W(LED_W), .SEL_W(SEL_W), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Data(Data), .ZF(ZF), .OF(OF), .Sel(Sel), .Auto(Auto),
    .Freeze(Freeze), .ClrSticky(ClrSticky), .LED(LED), .PageIdx(PageIdx)
  );

  always #5 Clk = ~Clk;

  // Reference model: captured words, flags, and cycles elapsed since auto entry.
  int unsigned m_cap [NCH];
  bit m_czf, m_cof, m_szf, m_sof, m_prev_auto;
  int m_k;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [LED_W-1:0] led;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) m_cap[c] = 0;
    m_czf = 0; m_cof = 0; m_szf = 0; m_sof = 0; m_prev_auto = 0; m_k = 0;
  endtask

  function automatic int model_led(input int page);
    if (page < NCH * NSL)
      return int'((m_cap[page / NSL] >> ((page % NSL) * LED_W)) & 32'hFF);
    else if (page == NPAGE - 1)
      return (int'(m_cof) << 7) | (int'(m_czf) << 6) | (int'(m_sof) << 5) | (int'(m_szf) << 4);
    else
      return 0;
  endfunction

  // One clock: predict from pre-edge state and inputs, then compare after the edge.
  task automatic step();
    int page;
    int el;
    @(posedge Clk);
    if (Rst) begin
      model_reset();
      page = 0;
      el   = 0;
    end else begin
      if (Auto) begin
        m_k  = m_prev_auto ? m_k + 1 : 0;
        page = (m_k / SCAN_DIV) % NPAGE;
      end else begin
        page = int'(Sel);
      end
      el = model_led(page);
      if (!Freeze) begin
        for (int c = 0; c < NCH; c++) m_cap[c] = Data[c*DATA_W +: DATA_W];
        m_czf = ZF;
        m_cof = OF;
      end
      m_szf = (m_szf && !ClrSticky) || ZF;
      m_sof = (m_sof && !ClrSticky) || OF;
      m_prev_auto = Auto;
    end
    #1;
    check("model_led", int'(LED), el);
    check("model_pageidx", int'(PageIdx), page);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen [40];
    bit found;
    model_reset();

    // Reset with nonzero data on the inputs
    Data = {32'hDEADBEEF, 32'hCAFEF00D};
    step(); step();
    check("reset_led", int'(LED), 0);
    check("reset_pageidx", int'(PageIdx), 0);
    Rst = 1'b0; Auto = 1'b0; Sel = 0;
    Data = {32'h11223344, 32'hA1B2C3D4};
    step(); step();
    check("release_led_d4", int'(LED), 8'hD4);

    // Manual sweep vectors
    tbl[0]  = '{4'd0, 8'hD4}; tbl[1]  = '{4'd1, 8'hC3}; tbl[2]  = '{4'd2, 8'hB2};
    tbl[3]  = '{4'd3, 8'hA1}; tbl[4]  = '{4'd4, 8'h44}; tbl[5]  = '{4'd5, 8'h33};
    tbl[6]  = '{4'd6, 8'h22}; tbl[7]  = '{4'd7, 8'h11}; tbl[8]  = '{4'd8, 8'h00};
    for (int i = 9; i < 16; i++) tbl[i] = '{4'(i), 8'h00};
    for (int i = 0; i < 16; i++) begin
      Sel = tbl[i].sel;
      step();
      check("sweep_led", int'(LED), int'(tbl[i].led));
      check("sweep_pageidx", int'(PageIdx), int'(tbl[i].sel));
    end

    // Auto scan: dwell of SCAN_DIV clocks per page and wrap back to page 0
    Auto = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      seen[k] = int'(PageIdx);
    end
    for (int k = 0; k < 40; k++) check("auto_seq", seen[k], (k / SCAN_DIV) % NPAGE);
    check("auto_last_page", seen[35], 8);
    check("auto_wrap", seen[36], 0);

    // Freeze holds the snapshot
    Auto = 1'b0; Sel = 0; Freeze = 1'b1;
    step();
    Data[31:0] = 32'hFFFFFFFF;
    step(); step(); step();
    check("freeze_hold", int'(LED), 8'hD4);
    Freeze = 1'b0;
    step(); step();
    check("unfreeze_ff", int'(LED), 8'hFF);

    // Sticky flags
    Sel = 8; ZF = 1'b1;
    step();
    ZF = 1'b0;
    step();
    check("sticky_pulse", int'(LED), 8'h50);
    step();
    check("sticky_held", int'(LED), 8'h10);
    ClrSticky = 1'b1; ZF = 1'b1;
    step();
    ClrSticky = 1'b0; ZF = 1'b0;
    step();
    check("sticky_set_wins", int'(LED), 8'h50);
    step();
    check("sticky_after_set_wins", int'(LED), 8'h10);
    ClrSticky = 1'b1;
    step();
    ClrSticky = 1'b0;
    step();
    check("sticky_cleared", int'(LED), 8'h00);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      Data      = {$urandom, $urandom};
      Sel       = 4'($urandom_range(0, 15));
      ZF        = ($urandom_range(0, 7) == 0);
      OF        = ($urandom_range(0, 7) == 0);
      ClrSticky = ($urandom_range(0, 7) == 0);
      Freeze    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) Auto = ~Auto;
      step();
    end
    ZF = 1'b0; OF = 1'b0; ClrSticky = 1'b0; Freeze = 1'b0;

    // Asynchronous reset while auto-scanning on page 5
    Auto = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (PageIdx == 5) found = 1'b1;
    end
    check("reach_page5", int'(found), 1);
    #2;
    Rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_led", int'(LED), 0);
    check("async_rst_pageidx", int'(PageIdx), 0);
    step();
    Rst = 1'b0;
    for (int k = 0; k < SCAN_DIV; k++) begin
      step();
      check("resume_page0", int'(PageIdx), 0);
    end
    step();
    check("resume_page1", int'(PageIdx), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
